// File: rtl/gate_result_checker.sv
// Checks a seven-output logic-gate block against its expected truth table
// over a run of N_VECTORS accepted samples and keeps per-run result registers.
module gate_result_checker #(
    parameter int N_VECTORS = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [1:0]       entrada,
    input  logic             NOT_A,
    input  logic             OR,
    input  logic             AND,
    input  logic             NOR,
    input  logic             NAND,
    input  logic             XOR,
    input  logic             XNOR,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [6:0]       fail_mask,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_entrada
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [6:0]       fail_mask_q, fail_mask_d;
    logic             ff_valid_q, ff_valid_d;
    logic [1:0]       ff_entrada_q, ff_entrada_d;
    // vec_count may be narrower than N_VECTORS, so run length is tracked separately
    logic [7:0]       run_cnt_q, run_cnt_d;

    logic       a, b;
    logic [6:0] got, expect_v, mismatch;
    logic       accept, last_sample;

    assign a        = entrada[1];
    assign b        = entrada[0];
    assign got      = {NOT_A, OR, AND, NOR, NAND, XOR, XNOR};
    assign expect_v = {~a, a | b, a & b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b)};
    assign mismatch = got ^ expect_v;

    assign accept      = (state_q == RUN) && in_valid;
    assign last_sample = accept && (run_cnt_q == 8'(N_VECTORS - 1));

    always_comb begin
        state_d      = state_q;
        err_count_d  = err_count_q;
        vec_count_d  = vec_count_q;
        fail_mask_d  = fail_mask_q;
        ff_valid_d   = ff_valid_q;
        ff_entrada_d = ff_entrada_q;
        run_cnt_d    = run_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    err_count_d  = '0;
                    vec_count_d  = '0;
                    fail_mask_d  = '0;
                    ff_valid_d   = 1'b0;
                    ff_entrada_d = '0;
                    run_cnt_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    run_cnt_d   = run_cnt_q + 8'd1;
                    vec_count_d = vec_count_q + 1'b1;
                    fail_mask_d = fail_mask_q | mismatch;
                    if (|mismatch) begin
                        if (!(&err_count_q)) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!ff_valid_q) begin
                            ff_valid_d   = 1'b1;
                            ff_entrada_d = entrada;
                        end
                    end
                    if (last_sample) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_count_q  <= '0;
            vec_count_q  <= '0;
            fail_mask_q  <= '0;
            ff_valid_q   <= 1'b0;
            ff_entrada_q <= '0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_count_q  <= err_count_d;
            vec_count_q  <= vec_count_d;
            fail_mask_q  <= fail_mask_d;
            ff_valid_q   <= ff_valid_d;
            ff_entrada_q <= ff_entrada_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = done_q && (err_count_q == '0);
    assign err_count          = err_count_q;
    assign vec_count          = vec_count_q;
    assign fail_mask          = fail_mask_q;
    assign first_fail_valid   = ff_valid_q;
    assign first_fail_entrada = ff_entrada_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Table-driven bench for gate_result_checker with a per-sample scoreboard;
// a second instance (CNT_W=2, N_VECTORS=6) covers counter saturation.
module tb_gate_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, start2, in_valid2;
    logic [1:0] entrada;
    logic [6:0] gates;

    logic       busy, done, pass, ffv;
    logic [7:0] err_count, vec_count;
    logic [6:0] fail_mask;
    logic [1:0] ffe;

    logic       busy2, done2, pass2, ffv2;
    logic [1:0] err2, vec2;
    logic [6:0] mask2;
    logic [1:0] ffe2;

    gate_result_checker #(.N_VECTORS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .entrada(entrada),
        .NOT_A(gates[6]), .OR(gates[5]), .AND(gates[4]), .NOR(gates[3]),
        .NAND(gates[2]), .XOR(gates[1]), .XNOR(gates[0]),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_count(vec_count), .fail_mask(fail_mask),
        .first_fail_valid(ffv), .first_fail_entrada(ffe)
    );

    gate_result_checker #(.N_VECTORS(6), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .entrada(entrada),
        .NOT_A(gates[6]), .OR(gates[5]), .AND(gates[4]), .NOR(gates[3]),
        .NAND(gates[2]), .XOR(gates[1]), .XNOR(gates[0]),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .vec_count(vec2), .fail_mask(mask2),
        .first_fail_valid(ffv2), .first_fail_entrada(ffe2)
    );

    typedef struct packed {
        logic [3:0][6:0] flt;
        logic            gap;
        logic [7:0]      exp_err;
        logic [6:0]      exp_mask;
        logic            exp_ffv;
        logic [1:0]      exp_ffe;
        logic            exp_pass;
    } run_t;

    typedef struct {
        int         vec;
        int         err;
        logic [6:0] mask;
    } exp_t;

    run_t tbl [5];
    exp_t sbq [$];

    int n_checks = 0;
    int n_fail   = 0;

    int         m_err, m_vec;
    logic [6:0] m_mask;
    logic       m_ffv;
    logic [1:0] m_ffe;

    function automatic logic [6:0] good(input logic [1:0] e);
        logic a, b;
        a = e[1];
        b = e[0];
        return {~a, a | b, a & b, ~(a | b), ~(a & b), a ^ b, ~(a ^ b)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample1(input logic [1:0] e, input logic [6:0] flt, input logic st);
        exp_t x;
        entrada  = e;
        gates    = good(e) ^ flt;
        in_valid = 1'b1;
        start    = st;
        m_vec++;
        m_mask |= flt;
        if (flt != 7'd0) begin
            if (m_err < 255) m_err++;
            if (!m_ffv) begin
                m_ffv = 1'b1;
                m_ffe = e;
            end
        end
        x.vec = m_vec; x.err = m_err; x.mask = m_mask;
        sbq.push_back(x);
        step();
        in_valid = 1'b0;
        start    = 1'b0;
        x = sbq.pop_front();
        $display("sample e=%0d flt=%b vec=%0d err=%0d mask=%b", e, flt, vec_count, err_count, fail_mask);
        chk("vec_count", int'(vec_count), x.vec);
        chk("err_count", int'(err_count), x.err);
        chk("fail_mask", int'(fail_mask), int'(x.mask));
        chk("first_fail_valid", int'(ffv), int'(m_ffv));
        chk("first_fail_entrada", int'(ffe), int'(m_ffe));
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        m_err = 0; m_vec = 0; m_mask = '0; m_ffv = 1'b0; m_ffe = '0;
        chk("busy_after_start", int'(busy), 1);
        chk("done_after_start", int'(done), 0);
        chk("vec_after_start", int'(vec_count), 0);
        chk("err_after_start", int'(err_count), 0);
        chk("mask_after_start", int'(fail_mask), 0);
        chk("ffv_after_start", int'(ffv), 0);
    endtask

    task automatic run1(input int idx);
        run_t r;
        r = tbl[idx];
        $display("run %0d gap=%0d", idx, r.gap);
        if (r.gap) begin
            // pulses outside RUN must not disturb the held results
            for (int p = 0; p < 2; p++) begin
                entrada  = 2'(p);
                gates    = ~good(2'(p));
                in_valid = 1'b1;
                step();
                in_valid = 1'b0;
                chk("idle_valid_vec", int'(vec_count), m_vec);
                chk("idle_valid_err", int'(err_count), m_err);
            end
        end
        start_run();
        for (int i = 0; i < 4; i++) begin
            if (r.gap) begin
                step();
                step();
                chk("gap_vec_hold", int'(vec_count), m_vec);
            end
            sample1(2'(i), r.flt[i], r.gap && (i == 1));
            chk(i < 3 ? "done_early" : "done_final", int'(done), i == 3 ? 1 : 0);
            chk(i < 3 ? "busy_mid" : "busy_final", int'(busy), i < 3 ? 1 : 0);
            if (i < 3) chk("pass_mid", int'(pass), 0);
        end
        chk("final_err", int'(err_count), int'(r.exp_err));
        chk("final_mask", int'(fail_mask), int'(r.exp_mask));
        chk("final_ffv", int'(ffv), int'(r.exp_ffv));
        chk("final_ffe", int'(ffe), int'(r.exp_ffe));
        chk("final_pass", int'(pass), int'(r.exp_pass));
        chk("final_vec", int'(vec_count), 4);
        step();
        chk("done_hold", int'(done), 1);
        chk("err_hold", int'(err_count), int'(r.exp_err));
    endtask

    initial begin
        tbl[0] = '{flt: '0, gap: 1'b0, exp_err: 8'd0, exp_mask: 7'b0000000, exp_ffv: 1'b0, exp_ffe: 2'b00, exp_pass: 1'b1};
        tbl[1] = '{flt: '0, gap: 1'b0, exp_err: 8'd1, exp_mask: 7'b0000010, exp_ffv: 1'b1, exp_ffe: 2'b10, exp_pass: 1'b0};
        tbl[1].flt[2] = 7'b0000010;
        tbl[2] = '{flt: '0, gap: 1'b0, exp_err: 8'd2, exp_mask: 7'b1010100, exp_ffv: 1'b1, exp_ffe: 2'b01, exp_pass: 1'b0};
        tbl[2].flt[1] = 7'b1000000;
        tbl[2].flt[3] = 7'b0010100;
        tbl[3] = '{flt: '0, gap: 1'b1, exp_err: 8'd0, exp_mask: 7'b0000000, exp_ffv: 1'b0, exp_ffe: 2'b00, exp_pass: 1'b1};
        tbl[4] = '{flt: '0, gap: 1'b0, exp_err: 8'd2, exp_mask: 7'b1111111, exp_ffv: 1'b1, exp_ffe: 2'b00, exp_pass: 1'b0};
        tbl[4].flt[0] = 7'b1111111;
        tbl[4].flt[3] = 7'b0000001;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; start2 = 1'b0; in_valid2 = 1'b0;
        entrada = '0; gates = good(2'b00);
        m_err = 0; m_vec = 0; m_mask = '0; m_ffv = 1'b0; m_ffe = '0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_vec", int'(vec_count), 0);
        chk("rst_mask", int'(fail_mask), 0);
        chk("rst_ffv", int'(ffv), 0);
        chk("rst_ffe", int'(ffe), 0);
        chk("rst_busy2", int'(busy2), 0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) run1(k);

        // reset mid-run, asserted together with start and in_valid
        $display("reset mid-run");
        start_run();
        sample1(2'd0, 7'b0000001, 1'b0);
        sample1(2'd1, 7'b0000000, 1'b0);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; entrada = 2'd2; gates = ~good(2'd2);
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("mr_busy", int'(busy), 0);
        chk("mr_done", int'(done), 0);
        chk("mr_pass", int'(pass), 0);
        chk("mr_err", int'(err_count), 0);
        chk("mr_vec", int'(vec_count), 0);
        chk("mr_mask", int'(fail_mask), 0);
        chk("mr_ffv", int'(ffv), 0);
        chk("mr_ffe", int'(ffe), 0);
        step();
        chk("mr_idle_busy", int'(busy), 0);
        m_err = 0; m_vec = 0; m_mask = '0; m_ffv = 1'b0; m_ffe = '0;
        run1(0);

        // saturation on the narrow instance
        $display("saturation run");
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sat_busy_start", int'(busy2), 1);
        for (int k = 1; k <= 6; k++) begin
            exp_t x;
            entrada   = 2'(k % 4);
            gates     = ~good(2'(k % 4));
            in_valid2 = 1'b1;
            x.vec = k % 4; x.err = (k < 3) ? k : 3; x.mask = 7'h7F;
            sbq.push_back(x);
            step();
            in_valid2 = 1'b0;
            x = sbq.pop_front();
            $display("sat sample %0d vec=%0d err=%0d done=%0d", k, vec2, err2, done2);
            chk("sat_vec", int'(vec2), x.vec);
            chk("sat_err", int'(err2), x.err);
            chk("sat_mask", int'(mask2), int'(x.mask));
            chk("sat_done", int'(done2), k == 6 ? 1 : 0);
        end
        chk("sat_pass", int'(pass2), 0);
        chk("sat_busy_end", int'(busy2), 0);
        chk("sat_ffe", int'(ffe2), 1);
        chk("sat_ffv", int'(ffv2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
